udp_rx_dispatch_3: RTL and testbench

- Receive-side counterpart of the three-way TX arbiter. Accepts the MAC RX word stream (32-bit, sop/eop/mod/wren) and classifies each frame from its Ethernet/IPv4/UDP headers.
- Steers each whole frame to one of three consumers: port 1 = ARP+ICMP, port 2 = UDP1, port 3 = UDP2. All other frames are dropped.
- A 16-word buffer holds header words until the routing decision is known.

---
 rtl/udp_rx_dispatch_3_pkg.sv | 28 ++
 rtl/udp_rx_dispatch_3_rx_hdr_fifo.sv | 51 +++++
 rtl/udp_rx_dispatch_3.sv | 220 ++++++++++++++++++++++
 tb/tb_udp_rx_dispatch_3.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_dispatch_3_pkg.sv
// Shared constants and types for the three-way UDP receive dispatcher.
package udp_rx_dispatch_3_pkg;

    localparam logic [15:0] ETH_ARP       = 16'h0806;
    localparam logic [15:0] ETH_IP        = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    localparam logic [3:0]  WC_ETHTYPE    = 4'd3;
    localparam logic [3:0]  WC_PROTO      = 4'd5;
    localparam logic [3:0]  WC_DPORT      = 4'd9;

    typedef enum logic [1:0] {
        DEC_DROP = 2'd0,
        DEC_P1   = 2'd1,
        DEC_P2   = 2'd2,
        DEC_P3   = 2'd3
    } dec_e;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic [31:0] data;
    } buf_word_t;

endpackage

// File: rtl/udp_rx_dispatch_3_rx_hdr_fifo.sv
// Header/frame word buffer; can retro-mark the newest stored word as end of frame.
module udp_rx_dispatch_3_rx_hdr_fifo
    import udp_rx_dispatch_3_pkg::*;
#(
    parameter int BUF_AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  buf_word_t       wdata_i,
    input  logic            pop_i,
    input  logic            set_eop_i,
    output buf_word_t       rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [BUF_AW:0] count_o
);

    localparam int DEPTH = 1 << BUF_AW;

    buf_word_t         mem_q [DEPTH];
    logic [BUF_AW:0]   wr_ptr_q;
    logic [BUF_AW:0]   rd_ptr_q;
    logic [BUF_AW-1:0] last_addr;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (count_o == (BUF_AW+1)'(DEPTH));
    assign last_addr = wr_ptr_q[BUF_AW-1:0] - BUF_AW'(1);
    assign rdata_o   = mem_q[rd_ptr_q[BUF_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (BUF_AW+1)'(1);
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (BUF_AW+1)'(1);
        end
    end

    // Truncation targets the word before the write pointer, never the slot being written.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[BUF_AW-1:0]] <= wdata_i;
        if (set_eop_i && !empty_o) begin
            mem_q[last_addr].eop <= 1'b1;
            mem_q[last_addr].mod <= 2'd0;
        end
    end

endmodule

// File: rtl/udp_rx_dispatch_3.sv
// Classifies MAC RX frames from their headers and steers each whole frame to
// ARP/ICMP, UDP1 or UDP2 consumers, dropping everything else.
module udp_rx_dispatch_3
    import udp_rx_dispatch_3_pkg::*;
#(
    parameter logic [15:0] UDP1_PORT = 16'd5000,
    parameter logic [15:0] UDP2_PORT = 16'd5001,
    parameter int          BUF_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_wren,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [1:0]  rx_mod,
    input  logic [31:0] rx_data,
    output logic        rx_wren1,
    output logic        rx_sop1,
    output logic        rx_eop1,
    output logic [1:0]  rx_mod1,
    output logic [31:0] rx_data1,
    output logic        rx_wren2,
    output logic        rx_sop2,
    output logic        rx_eop2,
    output logic [1:0]  rx_mod2,
    output logic [31:0] rx_data2,
    output logic        rx_wren3,
    output logic        rx_sop3,
    output logic        rx_eop3,
    output logic [1:0]  rx_mod3,
    output logic [31:0] rx_data3,
    output logic [15:0] drop_cnt
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_e;

    logic            in_frame_q, in_frame_d;
    logic            decided_q, decided_d;
    logic [3:0]      wc_q, wc_d;
    logic [15:0]     drop_cnt_q;
    logic [16:0]     drop_sum;
    logic [1:0]      ndrop;

    logic            accept, abort, gone, undecided_now;
    logic [3:0]      widx;
    logic            cls_valid;
    dec_e            cls_dec;
    logic            push_a, push_b;
    dec_e            dec_b;
    logic            set_eop, close_set, close_q;

    buf_word_t       wr_word, head;
    logic            buf_full, buf_empty;
    logic [BUF_AW:0] buf_count;

    dec_e            dq_mem_q [4];
    logic [1:0]      dq_wr_q, dq_rd_q;
    logic [2:0]      dq_cnt_q;
    logic            dq_we0, dq_we1, pop_dec;
    dec_e            dq_v0, dq_head;

    state_e          state_q;
    logic            pop_buf, frame_end;
    logic [2:0]      wren_q, sop_q, eop_q;
    logic [2:0][1:0] mod_q;
    logic [2:0][31:0] data_q;

    always_comb begin
        cls_valid = 1'b0;
        cls_dec   = DEC_DROP;
        case (widx)
            WC_ETHTYPE: begin
                cls_valid = !(rx_data[31:16] == ETH_IP && rx_data[15:8] == IP_VER_IHL);
                cls_dec   = (rx_data[31:16] == ETH_ARP) ? DEC_P1 : DEC_DROP;
            end
            WC_PROTO: begin
                cls_valid = (rx_data[7:0] != IP_PROTO_UDP);
                cls_dec   = (rx_data[7:0] == IP_PROTO_ICMP) ? DEC_P1 : DEC_DROP;
            end
            WC_DPORT: begin
                cls_valid = 1'b1;
                cls_dec   = (rx_data[31:16] == UDP1_PORT) ? DEC_P2 :
                            (rx_data[31:16] == UDP2_PORT) ? DEC_P3 : DEC_DROP;
            end
            default: ;
        endcase
    end

    always_comb begin
        accept        = rx_wren && (rx_sop || in_frame_q);
        abort         = rx_wren && rx_sop && in_frame_q;
        widx          = rx_sop ? 4'd0 : wc_q;
        undecided_now = rx_sop || !decided_q;
        push_a        = abort && !decided_q;
        push_b        = accept && undecided_now && (buf_full || cls_valid || rx_eop);
        dec_b         = (cls_valid && !buf_full) ? cls_dec : DEC_DROP;
        // An open frame whose last word has already left the buffer is closed via close_q.
        gone          = buf_empty || (buf_count == (BUF_AW+1)'(1) && pop_buf);
        set_eop       = abort && !gone;
        close_set     = abort && gone;
        wr_word       = '{sop: rx_sop, eop: rx_eop, mod: rx_mod, data: rx_data};

        in_frame_d = in_frame_q;
        decided_d  = decided_q;
        wc_d       = wc_q;
        if (accept) begin
            in_frame_d = !rx_eop;
            decided_d  = !undecided_now || push_b;
            wc_d       = rx_sop ? 4'd1 : ((wc_q == 4'hF) ? wc_q : wc_q + 4'd1);
        end

        dq_v0   = push_a ? DEC_DROP : dec_b;
        dq_we0  = (push_a || push_b) && (dq_cnt_q < 3'd4);
        dq_we1  = push_a && push_b && (dq_cnt_q < 3'd3);
        dq_head = dq_mem_q[dq_rd_q];

        ndrop    = {1'b0, push_a} + {1'b0, push_b && (dec_b == DEC_DROP)};
        drop_sum = {1'b0, drop_cnt_q} + {15'd0, ndrop};

        pop_buf   = (state_q == ST_STREAM) && !close_q && !buf_empty;
        frame_end = (state_q == ST_STREAM) && (close_q || (pop_buf && head.eop));
        pop_dec   = frame_end && (dq_cnt_q != 3'd0);
    end

    udp_rx_dispatch_3_rx_hdr_fifo #(.BUF_AW(BUF_AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept),
        .wdata_i   (wr_word),
        .pop_i     (pop_buf),
        .set_eop_i (set_eop),
        .rdata_o   (head),
        .full_o    (buf_full),
        .empty_o   (buf_empty),
        .count_o   (buf_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q <= 1'b0;
            decided_q  <= 1'b0;
            wc_q       <= '0;
            dq_wr_q    <= '0;
            dq_rd_q    <= '0;
            dq_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            decided_q  <= decided_d;
            wc_q       <= wc_d;
            dq_wr_q    <= dq_wr_q + {1'b0, dq_we0} + {1'b0, dq_we1};
            dq_rd_q    <= dq_rd_q + {1'b0, pop_dec};
            dq_cnt_q   <= dq_cnt_q + {2'd0, dq_we0} + {2'd0, dq_we1} - {2'd0, pop_dec};
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (dq_we0) dq_mem_q[dq_wr_q]         <= dq_v0;
        if (dq_we1) dq_mem_q[dq_wr_q + 2'd1] <= dec_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            close_q <= 1'b0;
            wren_q  <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
            mod_q   <= '0;
            data_q  <= '0;
        end else begin
            wren_q <= '0;
            sop_q  <= '0;
            eop_q  <= '0;
            mod_q  <= '0;
            data_q <= '0;
            if (close_set)
                close_q <= 1'b1;
            else if (frame_end && close_q)
                close_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!buf_empty && dq_cnt_q != 3'd0) state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    for (int p = 0; p < 3; p++) begin
                        if (pop_buf && int'(dq_head) == p + 1) begin
                            wren_q[p] <= 1'b1;
                            sop_q[p]  <= head.sop;
                            eop_q[p]  <= head.eop;
                            mod_q[p]  <= head.mod;
                            data_q[p] <= head.data;
                        end
                    end
                    if (frame_end && dq_cnt_q < 3'd2) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_wren1 = wren_q[0];
    assign rx_sop1  = sop_q[0];
    assign rx_eop1  = eop_q[0];
    assign rx_mod1  = mod_q[0];
    assign rx_data1 = data_q[0];
    assign rx_wren2 = wren_q[1];
    assign rx_sop2  = sop_q[1];
    assign rx_eop2  = eop_q[1];
    assign rx_mod2  = mod_q[1];
    assign rx_data2 = data_q[1];
    assign rx_wren3 = wren_q[2];
    assign rx_sop3  = sop_q[2];
    assign rx_eop3  = eop_q[2];
    assign rx_mod3  = mod_q[2];
    assign rx_data3 = data_q[2];
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_dispatch_3.sv
// Bench for udp_rx_dispatch_3: directed and random frames against a whole-frame reference model.
module tb_udp_rx_dispatch_3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_wren, rx_sop, rx_eop;
    logic [1:0]  rx_mod;
    logic [31:0] rx_data;
    logic        rx_wren1, rx_sop1, rx_eop1, rx_wren2, rx_sop2, rx_eop2, rx_wren3, rx_sop3, rx_eop3;
    logic [1:0]  rx_mod1, rx_mod2, rx_mod3;
    logic [31:0] rx_data1, rx_data2, rx_data3;
    logic [15:0] drop_cnt;

    udp_rx_dispatch_3 dut (
        .clk(clk), .rst(rst),
        .rx_wren(rx_wren), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_mod(rx_mod), .rx_data(rx_data),
        .rx_wren1(rx_wren1), .rx_sop1(rx_sop1), .rx_eop1(rx_eop1), .rx_mod1(rx_mod1), .rx_data1(rx_data1),
        .rx_wren2(rx_wren2), .rx_sop2(rx_sop2), .rx_eop2(rx_eop2), .rx_mod2(rx_mod2), .rx_data2(rx_data2),
        .rx_wren3(rx_wren3), .rx_sop3(rx_sop3), .rx_eop3(rx_eop3), .rx_mod3(rx_mod3), .rx_data3(rx_data3),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic [2:0]  wren_v, sop_v, eop_v;
    logic [1:0]  mod_v  [3];
    logic [31:0] data_v [3];
    assign wren_v = {rx_wren3, rx_wren2, rx_wren1};
    assign sop_v  = {rx_sop3, rx_sop2, rx_sop1};
    assign eop_v  = {rx_eop3, rx_eop2, rx_eop1};
    assign mod_v[0] = rx_mod1;  assign mod_v[1] = rx_mod2;  assign mod_v[2] = rx_mod3;
    assign data_v[0] = rx_data1; assign data_v[1] = rx_data2; assign data_v[2] = rx_data3;

    // Expected output words in order: {port(1..3), sop, eop, mod, data}
    logic [37:0] exp_q [$];
    logic [31:0] frm [$];
    logic [1:0]  frm_mod;
    int          model_drops = 0;
    int          word_cyc [64];
    int          last_sop_cyc [3];
    int          last_eop_cyc [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                if (wren_v[p]) begin
                    chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        chk("out_word", 64'({2'(p + 1), sop_v[p], eop_v[p], mod_v[p], data_v[p]}),
                            64'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    if (sop_v[p]) last_sop_cyc[p] = cyc;
                    if (eop_v[p]) last_eop_cyc[p] = cyc;
                end else begin
                    chk("idle_port_zero", 64'({sop_v[p], eop_v[p], mod_v[p], data_v[p]}), 64'd0);
                end
            end
        end
    end

    // Destination of a complete (or truncated) frame of n words, from the header rules.
    function automatic int classify(input int n);
        if (n < 4) return 0;
        if (frm[3][31:16] == 16'h0806) return 1;
        if (frm[3][31:16] != 16'h0800 || frm[3][15:8] != 8'h45) return 0;
        if (n < 6) return 0;
        if (frm[5][7:0] == 8'd1) return 1;
        if (frm[5][7:0] != 8'd17) return 0;
        if (n < 10) return 0;
        if (frm[9][31:16] == 16'd5000) return 2;
        if (frm[9][31:16] == 16'd5001) return 3;
        return 0;
    endfunction

    // kind: 0 ARP, 1 UDP, 2 ICMP, 3 TCP, 4 bad IHL, 5 IPv6
    task automatic build(input int kind, input int len, input logic [15:0] dport);
        logic [31:0] w;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (i == 3) begin
                case (kind)
                    0: w[31:16] = 16'h0806;
                    4: w[31:8]  = {16'h0800, 8'h46};
                    5: w[31:16] = 16'h86DD;
                    default: w[31:8] = {16'h0800, 8'h45};
                endcase
            end
            if (i == 5) begin
                case (kind)
                    1: w[7:0] = 8'd17;
                    2: w[7:0] = 8'd1;
                    3: w[7:0] = 8'd6;
                    default: ;
                endcase
            end
            if (i == 9 && kind == 1) w[31:16] = dport;
            frm.push_back(w);
        end
        frm_mod = 2'($urandom_range(0, 3));
    endtask

    task automatic expect_frame(input int n, input bit trunc);
        int d;
        logic [1:0] m;
        d = classify(n);
        if (d == 0) model_drops++;
        else begin
            for (int i = 0; i < n; i++) begin
                m = (i == n - 1 && !trunc) ? frm_mod : 2'd0;
                exp_q.push_back({2'(d), (i == 0), (i == n - 1), m, frm[i]});
            end
        end
    endtask

    task automatic send_words(input int from, input int to, input bit with_sop, input bit with_eop);
        for (int i = from; i <= to; i++) begin
            rx_wren = 1'b1;
            rx_sop  = with_sop && (i == from);
            rx_eop  = with_eop && (i == to);
            rx_mod  = rx_eop ? frm_mod : 2'd0;
            rx_data = frm[i];
            @(posedge clk);
            #1;
            word_cyc[i] = cyc;
        end
        rx_wren = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_mod = 2'd0; rx_data = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(model_drops));
        #1;
    endtask

    initial begin
        rx_wren = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_mod = 2'd0; rx_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", 64'({wren_v, sop_v, eop_v}), 64'd0);
        chk("reset_data", 64'({data_v[0], data_v[1]}), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ARP, 16 words
        build(0, 16, 16'd0);
        frm[3] = 32'h0806_0001;
        expect_frame(16, 0);
        send_words(0, 15, 1, 1);
        drain("arp");
        chk("arp_latency", 64'(last_sop_cyc[0]), 64'(word_cyc[3] + 2));

        // UDP to UDP1_PORT, 20 words
        build(1, 20, 16'h1388);
        expect_frame(20, 0);
        send_words(0, 19, 1, 1);
        drain("udp1");
        chk("udp1_latency", 64'(last_sop_cyc[1]), 64'(word_cyc[9] + 2));
        chk("udp1_no_drops", 64'(drop_cnt), 64'd0);

        // UDP2 then ICMP back to back
        build(1, 20, 16'h1389);
        expect_frame(20, 0);
        send_words(0, 19, 1, 1);
        build(2, 12, 16'd0);
        expect_frame(12, 0);
        send_words(0, 11, 1, 1);
        drain("b2b");
        chk("b2b_no_gap", 64'(last_sop_cyc[0]), 64'(last_eop_cyc[2] + 1));

        // Runt and UDP to unknown port
        build(1, 6, 16'd0);
        expect_frame(6, 0);
        send_words(0, 5, 1, 1);
        drain("runt");
        chk("runt_drop_1", 64'(drop_cnt), 64'd1);
        build(1, 14, 16'h0050);
        expect_frame(14, 0);
        send_words(0, 13, 1, 1);
        drain("port80");
        chk("port80_drop_2", 64'(drop_cnt), 64'd2);

        // New sop at word 4 of undecided IPv4 frame, then ARP
        build(1, 20, 16'h1388);
        expect_frame(4, 1);
        send_words(0, 3, 1, 0);
        build(0, 9, 16'd0);
        expect_frame(9, 0);
        send_words(0, 8, 1, 1);
        drain("abort");
        chk("abort_drop_3", 64'(drop_cnt), 64'd3);

        // Random frames
        for (int f = 0; f < 20; f++) begin
            int kind, len, sel;
            logic [15:0] dp;
            kind = $urandom_range(0, 5);
            len  = $urandom_range(2, 24);
            sel  = $urandom_range(0, 2);
            dp   = (sel == 0) ? 16'd5000 : (sel == 1) ? 16'd5001 : 16'($urandom);
            build(kind, len, dp);
            expect_frame(len, 0);
            send_words(0, len - 1, 1, 1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        drain("random");

        // Reset in the middle of a UDP frame
        build(1, 20, 16'h1388);
        expect_frame(20, 0);
        send_words(0, 11, 1, 0);
        rx_wren = 1'b1; rx_data = frm[12];
        rst = 1'b1;
        #1;
        chk("midrst_flags", 64'({wren_v, sop_v, eop_v}), 64'd0);
        chk("midrst_data", 64'({data_v[1], data_v[2]}), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        model_drops = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_words(13, 19, 0, 1);
        drain("trailing");
        build(1, 15, 16'h1389);
        expect_frame(15, 0);
        send_words(0, 14, 1, 1);
        drain("post_reset");
        chk("post_reset_latency", 64'(last_sop_cyc[2]), 64'(word_cyc[9] + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
